input_pattern: RTL and testbench

- Receive side of the memory game. print_pattern shows a sequence on led_1..led_8; this block captures the player's button presses and compares them, press by press, against the same sequence.
- Asserts check_pass or check_fail, then check_end, for the game FSM.
- Runs on the fast clock clk_1 (10 kHz or faster) and sits beside print_pattern. It is enabled after print_pattern_end.

---
 rtl/game_pkg.sv | 28 ++
 rtl/input_pattern_if.sv | 29 ++
 rtl/btn_debouncer.sv | 48 ++++
 rtl/input_pattern.sv | 154 +++++++++++++++
 tb/tb_input_pattern.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the memory game: capture FSM encoding, sequence sizing
// constants and the level-to-length mapping used by both pattern blocks.
package game_pkg;

  localparam int MAX_LEN = 16;
  localparam int CODE_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_PRESS,
    WAIT_RELEASE,
    PASS,
    FAIL
  } state_t;

  // N = 4 + 4*level, clamped to MAX_LEN from level 3 upward; evaluated in 5 bits.
  function automatic logic [4:0] len_from_level(input logic [2:0] level);
    logic [4:0] n;
    if (level >= 3'd3) begin
      n = 5'(MAX_LEN);
    end else begin
      n = 5'd4 + {level[1:0], 2'b00};
    end
    return n;
  endfunction

endpackage

// File: rtl/input_pattern_if.sv
// Bundle between the game FSM / player I/O and the input_pattern capture block,
// plus a debug view of the capture FSM state.
import game_pkg::*;

interface input_pattern_if;
  logic                      enable;
  logic [2:0]                level;
  logic [MAX_LEN*CODE_W-1:0] pattern_flat;
  logic [7:0]                btn;
  logic [7:0]                led_echo;
  logic [4:0]                press_count;
  logic                      check_pass;
  logic                      check_fail;
  logic                      check_end;
  state_t                    dbg_state;

  // Session protocol: the master raises enable to start a session and holds it;
  // the slave answers with a sticky check_end (plus pass or fail) that stays up
  // until the master drops enable, which returns the slave to IDLE on the next edge.
  modport master (
    output enable, level, pattern_flat, btn,
    input  led_echo, press_count, check_pass, check_fail, check_end, dbg_state
  );

  modport slave (
    input  enable, level, pattern_flat, btn,
    output led_echo, press_count, check_pass, check_fail, check_end, dbg_state
  );
endinterface

// File: rtl/btn_debouncer.sv
// One push button: 2-flop synchronizer followed by a stability counter; the
// output follows the synchronized level once it has differed for DEBOUNCE_CYCLES.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 200
) (
  input  logic clk_1,
  input  logic rst,
  input  logic btn_i,
  output logic db_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1_q, s2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any return of the synchronized level to the accepted level restarts the count,
  // so a bouncing contact never accumulates enough stable cycles.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/input_pattern.sv
// Memory-game receive side: debounces 8 buttons, compares presses against the
// latched sequence and reports pass/fail. Optional inter-press timeout: INPUT_TIMEOUT_EN.
import game_pkg::*;

module input_pattern #(
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic            clk_1,
  input  logic            rst,
  input_pattern_if.slave  bus
);

  logic [7:0]        db;
  logic [7:0]        db_prev_q;
  logic [7:0]        rise;
  logic              press;
  logic              multi;
  logic [CODE_W-1:0] code;

  state_t            state_q;
  logic [4:0]        count_q;
  logic [4:0]        n_q;
  logic              pass_q, fail_q, end_q;
  logic [CODE_W-1:0] pat_q [MAX_LEN];
  logic              timeout_hit;
  logic              match;

  for (genvar g = 0; g < 8; g++) begin : g_db
    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_1 (clk_1),
      .rst   (rst),
      .btn_i (bus.btn[g]),
      .db_o  (db[g])
    );
  end

  assign rise  = db & ~db_prev_q;
  assign press = |rise;
  assign multi = ($countones(db) > 1);

  always_comb begin
    code = '0;
    for (int i = 7; i >= 0; i--) begin
      if (rise[i]) code = CODE_W'(i);
    end
  end

  assign match = !multi && (code == pat_q[count_q[3:0]]);

`ifdef INPUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  assign timeout_hit = (tmo_q == TW'(TIMEOUT_CYCLES));

  // Runs only while waiting on the player; an accepted press restarts it.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (!bus.enable) begin
      tmo_q <= '0;
    end else if ((state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE)) begin
      if ((state_q == WAIT_PRESS) && press && match) begin
        tmo_q <= '0;
      end else if (!timeout_hit) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end else begin
      tmo_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      n_q       <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      end_q     <= 1'b0;
      db_prev_q <= '0;
      for (int k = 0; k < MAX_LEN; k++) pat_q[k] <= '0;
    end else begin
      db_prev_q <= db;
      if (!bus.enable) begin
        state_q <= IDLE;
        count_q <= '0;
        pass_q  <= 1'b0;
        fail_q  <= 1'b0;
        end_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= LOAD;
          LOAD: begin
            for (int k = 0; k < MAX_LEN; k++) begin
              pat_q[k] <= bus.pattern_flat[CODE_W*k +: CODE_W];
            end
            n_q     <= len_from_level(bus.level);
            count_q <= '0;
            // A button still held from the previous session must be released first.
            state_q <= (|db) ? WAIT_RELEASE : WAIT_PRESS;
          end
          WAIT_PRESS: begin
            if (press) begin
              if (match) begin
                count_q <= count_q + 5'd1;
                if ((count_q + 5'd1) == n_q) begin
                  state_q <= PASS;
                  pass_q  <= 1'b1;
                  end_q   <= 1'b1;
                end else begin
                  state_q <= WAIT_RELEASE;
                end
              end else begin
                state_q <= FAIL;
                fail_q  <= 1'b1;
                end_q   <= 1'b1;
              end
            end else if (timeout_hit) begin
              state_q <= FAIL;
              fail_q  <= 1'b1;
              end_q   <= 1'b1;
            end
          end
          WAIT_RELEASE: begin
            if (timeout_hit) begin
              state_q <= FAIL;
              fail_q  <= 1'b1;
              end_q   <= 1'b1;
            end else if (db == 8'h00) begin
              state_q <= WAIT_PRESS;
            end
          end
          PASS:    state_q <= PASS;
          FAIL:    state_q <= FAIL;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.led_echo    = db;
  assign bus.press_count = count_q;
  assign bus.check_pass  = pass_q;
  assign bus.check_fail  = fail_q;
  assign bus.check_end   = end_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_input_pattern.sv
// Directed bench for input_pattern with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100;
// the timeout scenario follows INPUT_TIMEOUT_EN.
import game_pkg::*;

module tb_input_pattern;

  logic clk_1;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [2:0] codes [16];

  input_pattern_if bus ();

  input_pattern #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .clk_1 (clk_1),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  task automatic apply_codes();
    logic [47:0] f;
    f = '0;
    for (int k = 0; k < 16; k++) f[3*k +: 3] = codes[k];
    bus.pattern_flat = f;
  endtask

  task automatic press(input logic [7:0] mask);
    @(negedge clk_1) bus.btn = mask;
    repeat (12) @(negedge clk_1);
    bus.btn = 8'h00;
    repeat (12) @(negedge clk_1);
  endtask

  task automatic start_session(input logic [2:0] lvl);
    @(negedge clk_1);
    bus.level  = lvl;
    bus.enable = 1'b1;
    repeat (3) @(negedge clk_1);
  endtask

  task automatic end_session();
    @(negedge clk_1);
    bus.enable = 1'b0;
    bus.btn    = 8'h00;
    repeat (12) @(negedge clk_1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.level = 3'd0;
    bus.pattern_flat = '0;
    bus.btn = 8'h00;
    #1;
    n_cmp++; if (bus.led_echo !== 8'h00) begin n_bad++; $display("FAIL reset_led_echo: got %0h want 0", bus.led_echo); end
    n_cmp++; if (bus.press_count !== 5'd0) begin n_bad++; $display("FAIL reset_press_count: got %0d want 0", bus.press_count); end
    n_cmp++; if ({bus.check_pass, bus.check_fail, bus.check_end} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {bus.check_pass, bus.check_fail, bus.check_end}); end
    n_cmp++; if (bus.dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, IDLE); end
    repeat (3) @(negedge clk_1);
    rst = 1'b0;
    repeat (2) @(negedge clk_1);
  endtask

  task automatic test_len4_pass();
    logic [7:0] seq [4];
    seq[0] = 8'h01; seq[1] = 8'h08; seq[2] = 8'h80; seq[3] = 8'h04;
    for (int k = 0; k < 16; k++) codes[k] = 3'd0;
    codes[0] = 3'd0; codes[1] = 3'd3; codes[2] = 3'd7; codes[3] = 3'd2;
    apply_codes();
    start_session(3'd0);
    n_cmp++; if (bus.dbg_state !== WAIT_PRESS) begin n_bad++; $display("FAIL len4_wait_state: got %0d want %0d", bus.dbg_state, WAIT_PRESS); end
    for (int i = 0; i < 4; i++) begin
      press(seq[i]);
      n_cmp++; if (bus.press_count !== 5'(i + 1)) begin n_bad++; $display("FAIL len4_count_%0d: got %0d want %0d", i, bus.press_count, i + 1); end
      n_cmp++; if (bus.check_pass !== (i == 3)) begin n_bad++; $display("FAIL len4_pass_%0d: got %b want %b", i, bus.check_pass, (i == 3)); end
    end
    n_cmp++; if (bus.check_end !== 1'b1) begin n_bad++; $display("FAIL len4_end: got %b want 1", bus.check_end); end
    n_cmp++; if (bus.check_fail !== 1'b0) begin n_bad++; $display("FAIL len4_no_fail: got %b want 0", bus.check_fail); end
    end_session();
    n_cmp++; if ({bus.check_pass, bus.check_end, bus.press_count} !== 7'd0) begin n_bad++; $display("FAIL len4_cleared: got %b/%b/%0d want 0/0/0", bus.check_pass, bus.check_end, bus.press_count); end
  endtask

  task automatic test_wrong_press();
    bit seen;
    for (int k = 0; k < 16; k++) codes[k] = 3'd0;
    codes[0] = 3'd1; codes[1] = 3'd6; codes[2] = 3'd5;
    apply_codes();
    start_session(3'd1);
    // Inputs changed after LOAD must not affect this session.
    bus.pattern_flat = '0;
    bus.level = 3'd0;
    press(8'h02);
    press(8'h40);
    n_cmp++; if (bus.press_count !== 5'd2) begin n_bad++; $display("FAIL wrong_count_before: got %0d want 2", bus.press_count); end
    @(negedge clk_1) bus.btn = 8'h10;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk_1);
      if (bus.led_echo[4]) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL wrong_echo_timeout: got 0 want 1"); end
    n_cmp++; if (bus.check_fail !== 1'b0) begin n_bad++; $display("FAIL wrong_fail_early: got %b want 0", bus.check_fail); end
    @(negedge clk_1);
    n_cmp++; if ({bus.check_fail, bus.check_end, bus.check_pass} !== 3'b110) begin n_bad++; $display("FAIL wrong_flags: got %b want 110", {bus.check_fail, bus.check_end, bus.check_pass}); end
    n_cmp++; if (bus.press_count !== 5'd2) begin n_bad++; $display("FAIL wrong_count_after: got %0d want 2", bus.press_count); end
    end_session();
  endtask

  task automatic test_bounce_chord();
    for (int k = 0; k < 16; k++) codes[k] = 3'd0;
    codes[0] = 3'd1;
    apply_codes();
    start_session(3'd0);
    @(negedge clk_1) bus.btn = 8'h02;
    @(negedge clk_1) bus.btn = 8'h00;
    @(negedge clk_1) bus.btn = 8'h02;
    @(negedge clk_1) bus.btn = 8'h00;
    repeat (12) @(negedge clk_1);
    n_cmp++; if (bus.led_echo !== 8'h00) begin n_bad++; $display("FAIL bounce_echo: got %0h want 0", bus.led_echo); end
    n_cmp++; if (bus.press_count !== 5'd0) begin n_bad++; $display("FAIL bounce_count: got %0d want 0", bus.press_count); end
    n_cmp++; if (bus.check_end !== 1'b0) begin n_bad++; $display("FAIL bounce_end: got %b want 0", bus.check_end); end
    @(negedge clk_1) bus.btn = 8'h42;
    repeat (12) @(negedge clk_1);
    n_cmp++; if (bus.led_echo !== 8'h42) begin n_bad++; $display("FAIL chord_echo: got %0h want 42", bus.led_echo); end
    n_cmp++; if ({bus.check_fail, bus.check_pass} !== 2'b10) begin n_bad++; $display("FAIL chord_fail: got %b want 10", {bus.check_fail, bus.check_pass}); end
    n_cmp++; if (bus.press_count !== 5'd0) begin n_bad++; $display("FAIL chord_count: got %0d want 0", bus.press_count); end
    end_session();
  endtask

  task automatic test_enable_drop();
    for (int k = 0; k < 16; k++) codes[k] = 3'(k % 8);
    apply_codes();
    start_session(3'd2);
    press(8'h01); press(8'h02); press(8'h04);
    n_cmp++; if (bus.press_count !== 5'd3) begin n_bad++; $display("FAIL drop_count_before: got %0d want 3", bus.press_count); end
    n_cmp++; if (bus.dbg_state !== WAIT_PRESS) begin n_bad++; $display("FAIL drop_state_before: got %0d want %0d", bus.dbg_state, WAIT_PRESS); end
    bus.enable = 1'b0;
    bus.btn = 8'h01;
    @(negedge clk_1);
    n_cmp++; if (bus.dbg_state !== IDLE) begin n_bad++; $display("FAIL drop_idle: got %0d want %0d", bus.dbg_state, IDLE); end
    n_cmp++; if ({bus.press_count, bus.check_pass, bus.check_fail, bus.check_end} !== 8'd0) begin n_bad++; $display("FAIL drop_cleared: got %0d/%b%b%b want 0/000", bus.press_count, bus.check_pass, bus.check_fail, bus.check_end); end
    repeat (12) @(negedge clk_1);
    bus.enable = 1'b1;
    repeat (3) @(negedge clk_1);
    n_cmp++; if (bus.dbg_state !== WAIT_RELEASE) begin n_bad++; $display("FAIL held_at_load: got %0d want %0d", bus.dbg_state, WAIT_RELEASE); end
    n_cmp++; if (bus.press_count !== 5'd0) begin n_bad++; $display("FAIL restart_count: got %0d want 0", bus.press_count); end
    bus.btn = 8'h00;
    repeat (12) @(negedge clk_1);
    n_cmp++; if (bus.dbg_state !== WAIT_PRESS) begin n_bad++; $display("FAIL release_state: got %0d want %0d", bus.dbg_state, WAIT_PRESS); end
    press(8'h01);
    n_cmp++; if (bus.press_count !== 5'd1) begin n_bad++; $display("FAIL restart_first: got %0d want 1", bus.press_count); end
    end_session();
  endtask

  task automatic test_len16_and_async_reset();
    for (int k = 0; k < 16; k++) codes[k] = 3'(k % 8);
    apply_codes();
    start_session(3'd5);
    for (int i = 0; i < 15; i++) press(8'h01 << (i % 8));
    n_cmp++; if ({bus.press_count, bus.check_pass} !== {5'd15, 1'b0}) begin n_bad++; $display("FAIL len16_at15: got %0d/%b want 15/0", bus.press_count, bus.check_pass); end
    press(8'h80);
    n_cmp++; if ({bus.press_count, bus.check_pass, bus.check_fail, bus.check_end} !== {5'd16, 3'b101}) begin n_bad++; $display("FAIL len16_pass: got %0d/%b%b%b want 16/101", bus.press_count, bus.check_pass, bus.check_fail, bus.check_end); end
    n_cmp++; if (bus.dbg_state !== PASS) begin n_bad++; $display("FAIL len16_state: got %0d want %0d", bus.dbg_state, PASS); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.press_count, bus.check_pass, bus.check_fail, bus.check_end} !== 8'd0) begin n_bad++; $display("FAIL async_reset_outputs: got %0d/%b%b%b want 0/000", bus.press_count, bus.check_pass, bus.check_fail, bus.check_end); end
    n_cmp++; if (bus.dbg_state !== IDLE) begin n_bad++; $display("FAIL async_reset_state: got %0d want %0d", bus.dbg_state, IDLE); end
    bus.enable = 1'b0;
    @(negedge clk_1) rst = 1'b0;
    repeat (2) @(negedge clk_1);
  endtask

  task automatic test_timeout();
    bit seen;
    for (int k = 0; k < 16; k++) codes[k] = 3'd0;
    apply_codes();
    @(negedge clk_1);
    bus.level = 3'd0;
    bus.enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_1);
      if (bus.dbg_state == WAIT_PRESS) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL timeout_reach_wait: got 0 want 1"); end
`ifdef INPUT_TIMEOUT_EN
    repeat (100) @(negedge clk_1);
    n_cmp++; if (bus.check_fail !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %b want 0", bus.check_fail); end
    @(negedge clk_1);
    n_cmp++; if ({bus.check_fail, bus.check_end} !== 2'b11) begin n_bad++; $display("FAIL timeout_fire: got %b want 11", {bus.check_fail, bus.check_end}); end
`else
    repeat (1000) @(negedge clk_1);
    n_cmp++; if ({bus.check_fail, bus.check_end} !== 2'b00) begin n_bad++; $display("FAIL no_timeout: got %b want 00", {bus.check_fail, bus.check_end}); end
`endif
    end_session();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_len4_pass();
    test_wrong_press();
    test_bounce_chord();
    test_enable_drop();
    test_len16_and_async_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
